// File: rtl/scramble_mod_seq.sv
// scramble_mod_seq: sequential modulo reducer for the scrambler datapath.
// A latched RW-bit random word is divided by N = MIN_N + mode*STEP.
// The divider is a restoring shift-subtract loop that runs one bit per cycle.
// The remainder is presented as index and the quotient as quotient.
// Handshake: start is accepted in IDLE, busy is high during RUN, and done pulses for one cycle.
module scramble_mod_seq #(
  parameter int RW    = 4,
  parameter int MW    = 2,
  parameter int IW    = 3,
  parameter int MIN_N = 2,
  parameter int STEP  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [RW-1:0] random,
  input  logic [MW-1:0] mode,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] index,
  output logic [RW-1:0] quotient
);

  // Remainder/modulus width: one guard bit above the index width.
  localparam int NW    = IW + 1;
  localparam int CW    = (RW > 1) ? $clog2(RW) : 1;
  localparam int MAX_N = MIN_N + ((1 << MW) - 1) * STEP;

  // Reject parameter sets whose modulus table cannot be represented.
  if (MIN_N < 1) begin : g_chk_min_n
    $error("scramble_mod_seq: MIN_N must be >= 1");
  end
  if ((1 << IW) < MAX_N) begin : g_chk_iw
    $error("scramble_mod_seq: IW too small for largest modulus");
  end
  if (RW < 2) begin : g_chk_rw
    $error("scramble_mod_seq: RW must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [RW-1:0] d_r;     // dividend shift register, MSB consumed first
  logic [RW-1:0] q_r;     // quotient accumulator
  logic [NW-1:0] rem_r;   // partial remainder, always < N
  logic [NW-1:0] n_r;     // modulus latched at start
  logic [CW-1:0] cnt_r;   // iterations left minus one

  logic [NW-1:0] n_sel_s;
  logic [NW-1:0] t_s;
  logic [NW-1:0] rem_next_s;
  logic          qbit_s;
  logic [RW-1:0] q_next_s;

  // Modulus selected by mode from the arithmetic table.
  always_comb begin
    n_sel_s = NW'(MIN_N) + NW'(mode) * NW'(STEP);
  end

  // One restoring division step.
  // rem_r < N <= 2^IW, so dropping rem_r's top bit while shifting loses nothing.
  always_comb begin
    t_s        = NW'({rem_r, d_r[RW-1]});
    rem_next_s = t_s;
    qbit_s     = 1'b0;
    if (t_s >= n_r) begin
      rem_next_s = t_s - n_r;
      qbit_s     = 1'b1;
    end else begin
      rem_next_s = t_s;
      qbit_s     = 1'b0;
    end
    q_next_s = RW'({q_r, qbit_s});
  end

  // Control FSM, datapath registers and registered outputs.
  // The final iteration writes straight to index/quotient.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= S_IDLE;
      d_r      <= {RW{1'b0}};
      q_r      <= {RW{1'b0}};
      rem_r    <= {NW{1'b0}};
      n_r      <= {NW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      index    <= {IW{1'b0}};
      quotient <= {RW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            d_r     <= random;
            n_r     <= n_sel_s;
            rem_r   <= {NW{1'b0}};
            q_r     <= {RW{1'b0}};
            cnt_r   <= CW'(RW - 1);
            busy    <= 1'b1;
            state_r <= S_RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          d_r   <= RW'({d_r, 1'b0});
          rem_r <= rem_next_s;
          q_r   <= q_next_s;
          if (cnt_r == {CW{1'b0}}) begin
            index    <= rem_next_s[IW-1:0];
            quotient <= q_next_s;
            done     <= 1'b1;
            busy     <= 1'b0;
            state_r  <= S_DONE;
          end else begin
            cnt_r   <= cnt_r - CW'(1);
            state_r <= S_RUN;
          end
        end
        S_DONE: begin
          // start is deliberately ignored here, spacing operations RW+2 apart.
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
